fifo_reader: RTL

- Consumer end of the FIFO push/pop interface: drains NUM_FIFOS parallel FIFOs round-robin, issuing pop strobes and capturing each FIFO's registered output word.
- Forwards captured words to a downstream sink with a valid strobe.
- Throttles on the downstream almost_full flag.
- Sits between the per-channel FIFO bank and the downstream mux/sink.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/fifo_reader.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO reader slice: state encodings, default sizes, index width helper.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fifo_pkg;

  localparam int DEF_DATA_SIZE = 6;
  localparam int DEF_NUM_FIFOS = 4;

  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] STALL  = 2'd2;

  // Channel index width; a single FIFO still gets a 1-bit index.
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin first-eligible search starting at a pointer; one-hot grant plus its index.
// Latency: purely combinational.
// Backpressure: none here; the caller decides whether the grant is used.
module rr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_FIFOS,
  parameter int SEL_W   = sel_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);

  logic [SEL_W-1:0] cand;

  // Walk from the pointer and keep the first requester; the index wraps naturally since NUM_REQ is a power of two.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = ptr + SEL_W'(off);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

  // Expand the winning index into a one-hot grant.
  always_comb begin
    grant = '0;
    if (found) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_reader.sv
// Drains NUM_FIFOS FIFOs round-robin with one-hot pops and forwards each popped word with valid_out/chan_out.
// Latency: fixed 2 cycles from the edge a pop is asserted to the edge its word appears on data_out.
// Backpressure: down_almost_full stops new pops at once (STALL); up to 2 in-flight words still drain. FIFO_READER_STATS_EN adds word_count/stall_seen.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int NUM_FIFOS = DEF_NUM_FIFOS,
  parameter int SEL_W     = sel_width(NUM_FIFOS)
) (
  input  logic                           clk,
  input  logic                           reset_L,
  input  logic [NUM_FIFOS-1:0]           fifo_empty,
  input  logic [NUM_FIFOS*DATA_SIZE-1:0] fifo_data,
  input  logic                           down_almost_full,
  output logic [NUM_FIFOS-1:0]           fifo_pop,
  output logic [DATA_SIZE-1:0]           data_out,
  output logic                           valid_out,
  output logic [SEL_W-1:0]               chan_out,
  output logic [1:0]                     state
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [7:0]                     word_count,
  output logic [0:0]                     stall_seen
`endif
);

  state_t                 state_next;
  logic                   any_ready;
  logic                   pop_en;
  logic [NUM_FIFOS-1:0]   elig;
  logic [NUM_FIFOS-1:0]   grant;
  logic [SEL_W-1:0]       grant_idx;
  logic                   grant_found;
  logic [SEL_W-1:0]       rr_ptr;
  logic                   p1_vld;
  logic [SEL_W-1:0]       p1_idx;
  logic                   p2_vld;
  logic [SEL_W-1:0]       p2_idx;
  logic [DATA_SIZE-1:0]   cap_word;

  // The empty flag lags a pop by a cycle, so the FIFO popped last edge must sit one cycle out.
  assign any_ready = ~&fifo_empty;
  assign elig      = ~fifo_empty & ~fifo_pop;
  assign cap_word  = fifo_data[p2_idx*DATA_SIZE +: DATA_SIZE];

  rr_arbiter #(
    .NUM_REQ (NUM_FIFOS),
    .SEL_W   (SEL_W)
  ) u_arb (
    .req   (elig),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .found (grant_found)
  );

  // Next-state and pop decision; backpressure outranks data availability in every state.
  always_comb begin
    state_next = state;
    pop_en     = 1'b0;
    case (state)
      IDLE: begin
        if (any_ready) state_next = down_almost_full ? STALL : ACTIVE;
      end
      ACTIVE: begin
        if (down_almost_full)  state_next = STALL;
        else if (!any_ready)   state_next = IDLE;
        else                   pop_en     = grant_found;
      end
      STALL: begin
        if (!down_almost_full) state_next = any_ready ? ACTIVE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, registered pop strobe and round-robin pointer (advances only past a granted FIFO).
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state    <= IDLE;
      fifo_pop <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_next;
      fifo_pop <= pop_en ? grant : '0;
      if (pop_en) rr_ptr <= grant_idx + SEL_W'(1);
    end
  end

  // Two-stage pending pipeline: pop edge -> FIFO register edge -> capture edge.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      p1_vld    <= 1'b0;
      p1_idx    <= '0;
      p2_vld    <= 1'b0;
      p2_idx    <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      chan_out  <= '0;
    end else begin
      p1_vld    <= pop_en;
      p1_idx    <= grant_idx;
      p2_vld    <= p1_vld;
      p2_idx    <= p1_idx;
      valid_out <= p2_vld;
      if (p2_vld) begin
        data_out <= cap_word;
        chan_out <= p2_idx;
      end
    end
  end

`ifdef FIFO_READER_STATS_EN
  // Delivered-word counter (wraps at 8 bits) and sticky flag set on every entry into STALL.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      word_count <= 8'd0;
      stall_seen <= 1'b0;
    end else begin
      if (valid_out) word_count <= word_count + 8'd1;
      if ((state_next == STALL) && (state != STALL)) stall_seen <= 1'b1;
    end
  end
`endif

endmodule
